// File: rtl/set_associative_replacement_unit.sv
// Per-set true-LRU age bank with a CPU access port and an independent snoop invalidate port.
// Optional `REPLACEMENT_INVALID_FIRST_EN adds per-way valid bits so invalid ways are victimised first.
module set_associative_replacement_unit #(
    parameter  int INDEX_WIDTH    = 6,
    parameter  int NUMBER_OF_WAYS = 4,
    localparam int WAY_WIDTH      = $clog2(NUMBER_OF_WAYS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] cpuIndexIn,
    input  logic                   cpuAccessEnable,
    input  logic [WAY_WIDTH-1:0]   cpuAccessedWay,
    input  logic [INDEX_WIDTH-1:0] snoopyIndexIn,
    input  logic                   snoopyInvalidateEnable,
    input  logic [WAY_WIDTH-1:0]   snoopyInvalidatedWay,
    output logic [WAY_WIDTH-1:0]   replacementWay,
    output logic                   cpuStall
);
    localparam int NUMBER_OF_SETS = 1 << INDEX_WIDTH;
    localparam logic [WAY_WIDTH-1:0] LRU_AGE = WAY_WIDTH'(NUMBER_OF_WAYS - 1);

    typedef logic [NUMBER_OF_WAYS-1:0][WAY_WIDTH-1:0] age_t;

    // Ages form a permutation of 0..N-1 per set: 0 is MRU, N-1 is LRU.
    age_t r_age [NUMBER_OF_SETS];

    logic                 w_same_set;
    logic                 w_cpu_accept;
    logic [WAY_WIDTH-1:0] w_lru_way;

    function automatic age_t f_touch(input age_t a, input logic [WAY_WIDTH-1:0] way);
        age_t                 n   = a;
        logic [WAY_WIDTH-1:0] old = a[way];
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (WAY_WIDTH'(w) == way)
                n[w] = '0;
            else if (a[w] < old)
                n[w] = a[w] + WAY_WIDTH'(1);
        end
        return n;
    endfunction

    function automatic age_t f_evict(input age_t a, input logic [WAY_WIDTH-1:0] way);
        age_t                 n   = a;
        logic [WAY_WIDTH-1:0] old = a[way];
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (WAY_WIDTH'(w) == way)
                n[w] = LRU_AGE;
            else if (a[w] > old)
                n[w] = a[w] - WAY_WIDTH'(1);
        end
        return n;
    endfunction

    // Same-set collision: the snoop owns the set this cycle, the CPU must retry.
    assign w_same_set   = cpuIndexIn == snoopyIndexIn;
    assign cpuStall     = ~reset & cpuAccessEnable & snoopyInvalidateEnable & w_same_set;
    assign w_cpu_accept = cpuAccessEnable & ~(snoopyInvalidateEnable & w_same_set);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUMBER_OF_SETS; s++)
                for (int w = 0; w < NUMBER_OF_WAYS; w++)
                    r_age[s][w] <= WAY_WIDTH'(w);
        end else begin
            if (w_cpu_accept)
                r_age[cpuIndexIn] <= f_touch(r_age[cpuIndexIn], cpuAccessedWay);
            if (snoopyInvalidateEnable)
                r_age[snoopyIndexIn] <= f_evict(r_age[snoopyIndexIn], snoopyInvalidatedWay);
        end
    end

    always_comb begin
        w_lru_way = '0;
        for (int w = 0; w < NUMBER_OF_WAYS; w++)
            if (r_age[cpuIndexIn][w] == LRU_AGE)
                w_lru_way = WAY_WIDTH'(w);
    end

`ifdef REPLACEMENT_INVALID_FIRST_EN
    logic [NUMBER_OF_WAYS-1:0] r_valid [NUMBER_OF_SETS];
    logic                      w_found_invalid;
    logic [WAY_WIDTH-1:0]      w_invalid_way;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUMBER_OF_SETS; s++)
                r_valid[s] <= '0;
        end else begin
            if (w_cpu_accept)
                r_valid[cpuIndexIn][cpuAccessedWay] <= 1'b1;
            if (snoopyInvalidateEnable)
                r_valid[snoopyIndexIn][snoopyInvalidatedWay] <= 1'b0;
        end
    end

    always_comb begin
        w_found_invalid = 1'b0;
        w_invalid_way   = '0;
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (!w_found_invalid && !r_valid[cpuIndexIn][w]) begin
                w_found_invalid = 1'b1;
                w_invalid_way   = WAY_WIDTH'(w);
            end
        end
    end

    assign replacementWay = w_found_invalid ? w_invalid_way : w_lru_way;
`else
    assign replacementWay = w_lru_way;
`endif

endmodule

// File: tb/tb_set_associative_replacement_unit.sv
// Directed bench for the LRU replacement unit: reset sweep, vector table, reset-pulse and
// (with REPLACEMENT_INVALID_FIRST_EN) invalid-first sequences.
module tb_set_associative_replacement_unit;
    localparam int IW = 6;
    localparam int NW = 4;
    localparam int WW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [IW-1:0] cpuIndexIn;
    logic          cpuAccessEnable;
    logic [WW-1:0] cpuAccessedWay;
    logic [IW-1:0] snoopyIndexIn;
    logic          snoopyInvalidateEnable;
    logic [WW-1:0] snoopyInvalidatedWay;
    logic [WW-1:0] replacementWay;
    logic          cpuStall;

    int checks = 0;
    int errors = 0;

    set_associative_replacement_unit #(.INDEX_WIDTH(IW), .NUMBER_OF_WAYS(NW)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .cpuIndexIn             (cpuIndexIn),
        .cpuAccessEnable        (cpuAccessEnable),
        .cpuAccessedWay         (cpuAccessedWay),
        .snoopyIndexIn          (snoopyIndexIn),
        .snoopyInvalidateEnable (snoopyInvalidateEnable),
        .snoopyInvalidatedWay   (snoopyInvalidatedWay),
        .replacementWay         (replacementWay),
        .cpuStall               (cpuStall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] ci;
        logic          ce;
        logic [WW-1:0] cw;
        logic [IW-1:0] si;
        logic          se;
        logic [WW-1:0] sw;
        logic [WW-1:0] exp_rep;
        logic          exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int ci, input int ce, input int cw, input int si,
                                input int se, input int sw, input int rep, input int stl);
        vec_t v;
        v.ci = IW'(ci); v.ce = ce[0]; v.cw = WW'(cw);
        v.si = IW'(si); v.se = se[0]; v.sw = WW'(sw);
        v.exp_rep = WW'(rep); v.exp_stall = stl[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input int ci, input int ce, input int cw, input int si, input int se, input int sw);
        cpuIndexIn = IW'(ci); cpuAccessEnable = ce[0]; cpuAccessedWay = WW'(cw);
        snoopyIndexIn = IW'(si); snoopyInvalidateEnable = se[0]; snoopyInvalidatedWay = WW'(sw);
    endtask

    // Inputs change at negedge, outputs sampled 1 time unit later, update at the next posedge.
    task automatic step(input string nm, input int ci, input int ce, input int cw,
                        input int si, input int se, input int sw, input int rep, input int stl);
        @(negedge clock);
        drive(ci, ce, cw, si, se, sw);
        #1;
        chk({nm, ".rep"}, 8'(replacementWay), 8'(rep));
        chk({nm, ".stall"}, 8'(cpuStall), 8'(stl));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Reset sweep with colliding enables: stall must stay low under reset.
        for (int i = 0; i < 64; i++) begin
            drive(i, 1, 2, i, 1, 1);
            #2;
            chk($sformatf("rst_rep[%0d]", i), 8'(replacementWay), 8'd3);
            chk($sformatf("rst_stall[%0d]", i), 8'(cpuStall), 8'd0);
        end
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;

`ifndef REPLACEMENT_INVALID_FIRST_EN
        //          ci ce cw  si se sw  rep stall  (rep/stall are pre-edge values)
        vecs.push_back(mk( 5, 1, 3,  0, 0, 0,  3, 0));
        vecs.push_back(mk( 5, 1, 2,  0, 0, 0,  2, 0));
        vecs.push_back(mk( 5, 0, 0,  0, 0, 0,  1, 0));
        vecs.push_back(mk( 6, 0, 0,  0, 0, 0,  3, 0));
        vecs.push_back(mk( 5, 0, 0,  5, 1, 3,  1, 0));
        vecs.push_back(mk( 5, 0, 0,  0, 0, 0,  3, 0));
        vecs.push_back(mk( 9, 1, 3,  9, 1, 3,  3, 1));
        vecs.push_back(mk( 9, 0, 0,  0, 0, 0,  3, 0));
        vecs.push_back(mk( 9, 1, 3, 10, 1, 0,  3, 0));
        vecs.push_back(mk( 9, 0, 0,  0, 0, 0,  2, 0));
        vecs.push_back(mk(10, 0, 0,  0, 0, 0,  0, 0));
        vecs.push_back(mk(11, 1, 3, 11, 1, 1,  3, 1));
        vecs.push_back(mk(11, 0, 0,  0, 0, 0,  1, 0));
        vecs.push_back(mk(11, 1, 0,  0, 0, 0,  1, 0));
        vecs.push_back(mk(11, 0, 0,  0, 0, 0,  1, 0));
        vecs.push_back(mk(12, 0, 0, 12, 1, 0,  3, 0));
        vecs.push_back(mk(12, 0, 0,  0, 0, 0,  0, 0));

        foreach (vecs[k])
            step($sformatf("vec%0d", k), int'(vecs[k].ci), int'(vecs[k].ce), int'(vecs[k].cw),
                 int'(vecs[k].si), int'(vecs[k].se), int'(vecs[k].sw),
                 int'(vecs[k].exp_rep), int'(vecs[k].exp_stall));

        // Set 5 ages are w0=1,w1=2,w2=0,w3=3; touching way 3 leaves way 1 as LRU.
        step("pre_rst", 5, 1, 3, 0, 0, 0, 3, 0);
        step("post_acc", 5, 0, 0, 0, 0, 0, 1, 0);
        #1 reset = 1'b1;
        #1 chk("rst_pulse_rep5", 8'(replacementWay), 8'd3);
        reset = 1'b0;
        for (int s = 9; s <= 12; s++) begin
            cpuIndexIn = IW'(s);
            #1 chk($sformatf("after_rst_rep%0d", s), 8'(replacementWay), 8'd3);
        end
`else
        step("inv_first_rst", 5, 1, 0, 0, 0, 0, 0, 0);
        step("acc_w0", 5, 0, 0, 5, 1, 0, 1, 0);
        step("inv_w0", 5, 1, 3, 0, 0, 0, 0, 0);
        step("fill3", 5, 1, 2, 0, 0, 0, 0, 0);
        step("fill2", 5, 1, 1, 0, 0, 0, 0, 0);
        step("fill1", 5, 1, 0, 0, 0, 0, 0, 0);
        step("all_valid", 5, 0, 0, 0, 0, 0, 3, 0);
        step("other_set", 6, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
